// File: rtl/sha256_core_arbiter.sv
// Two-requester round-robin front end for a byte-serial SHA-256 core: buffers a 16-word block, feeds it, packs the 32-byte digest.
// Optional WAIT watchdog is built only when SHA_ARB_TIMEOUT_EN is defined; otherwise err_out is tied low.
//
// state   | meaning
// IDLE    | no owner, waiting for any req_in
// LOAD    | accepting 16 words from the granted requester
// PRE     | core_start_out high with zero data for PRE_CYC cycles
// FEED    | buffered words 0..15 presented to the core, one per cycle
// WAIT    | waiting for the core's first digest byte
// COLLECT | packing digest bytes into words, then completion pulse
module sha256_core_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int PRE_CYC     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_in,
  output logic [1:0]            gnt_out,
  input  logic [1:0]            ld_valid_in,
  input  logic [DATA_WIDTH-1:0] ld_word0_in,
  input  logic [DATA_WIDTH-1:0] ld_word1_in,
  output logic [1:0]            ld_ready_out,
  output logic                  core_start_out,
  output logic [DATA_WIDTH-1:0] core_msg_out,
  input  logic [7:0]            core_hash_in,
  input  logic                  core_dv_in,
  output logic [31:0]           hash_word_out,
  output logic                  hash_valid_out,
  output logic [2:0]            hash_idx_out,
  output logic                  hash_dst_out,
  output logic [1:0]            done_out,
  output logic                  err_out
);

  // PRE is a down-counter that must see at least one cycle; both limits must be positive.
  if (PRE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("sha256_core_arbiter: PRE_CYC and TIMEOUT_CYC must be >= 1");
  end

  localparam int PW = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, PRE, FEED, WAIT, COLLECT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] msg_buf [16];
  logic [3:0]            word_cnt;
  logic [PW-1:0]         pre_cnt;
  logic [4:0]            byte_cnt;
  logic [23:0]           byte_acc;
  logic                  collect_fin;
  logic                  ptr;
  logic                  owner;

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] to_cnt;
`endif

  logic                  pick;
  logic                  owner_req;
  logic                  ld_fire;
  logic [DATA_WIDTH-1:0] ld_word;

  // ptr names the requester that wins a tie; it flips to the other side after a served block.
  always_comb begin
    pick      = req_in[ptr] ? ptr : ~ptr;
    owner_req = req_in[owner];
    ld_fire   = ld_valid_in[owner] & ld_ready_out[owner];
    ld_word   = owner ? ld_word1_in : ld_word0_in;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && owner_req && ld_fire)
      msg_buf[word_cnt] <= ld_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gnt_out        <= '0;
      ld_ready_out   <= '0;
      core_start_out <= 1'b0;
      core_msg_out   <= '0;
      hash_word_out  <= '0;
      hash_valid_out <= 1'b0;
      hash_idx_out   <= '0;
      hash_dst_out   <= 1'b0;
      done_out       <= '0;
      word_cnt       <= '0;
      pre_cnt        <= '0;
      byte_cnt       <= '0;
      byte_acc       <= '0;
      collect_fin    <= 1'b0;
      ptr            <= 1'b0;
      owner          <= 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
      err_out        <= 1'b0;
      to_cnt         <= '0;
`endif
    end else begin
      hash_valid_out <= 1'b0;
      done_out       <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
      err_out        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req_in) begin
            owner        <= pick;
            gnt_out      <= pick ? 2'b10 : 2'b01;
            ld_ready_out <= pick ? 2'b10 : 2'b01;
            word_cnt     <= '0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          // An abandoned block leaves ptr alone so the requester keeps its turn.
          if (!owner_req) begin
            gnt_out      <= '0;
            ld_ready_out <= '0;
            state        <= IDLE;
          end else if (ld_fire) begin
            word_cnt <= word_cnt + 4'd1;
            if (word_cnt == 4'd15) begin
              ld_ready_out   <= '0;
              core_start_out <= 1'b1;
              core_msg_out   <= '0;
              pre_cnt        <= PW'(PRE_CYC - 1);
              state          <= PRE;
            end
          end
        end
        PRE: begin
          if (pre_cnt == '0) begin
            core_msg_out <= msg_buf[0];
            word_cnt     <= '0;
            state        <= FEED;
          end else begin
            pre_cnt <= pre_cnt - 1'b1;
          end
        end
        FEED: begin
          if (word_cnt == 4'd15) begin
            core_start_out <= 1'b0;
            core_msg_out   <= '0;
            state          <= WAIT;
`ifdef SHA_ARB_TIMEOUT_EN
            to_cnt         <= TW'(TIMEOUT_CYC - 1);
`endif
          end else begin
            word_cnt     <= word_cnt + 4'd1;
            core_msg_out <= msg_buf[word_cnt + 4'd1];
          end
        end
        WAIT: begin
          // The core's valid cycle already carries digest byte 0.
          if (core_dv_in) begin
            byte_acc    <= {16'h0000, core_hash_in};
            byte_cnt    <= 5'd1;
            collect_fin <= 1'b0;
            state       <= COLLECT;
          end
`ifdef SHA_ARB_TIMEOUT_EN
          else if (to_cnt == '0) begin
            err_out <= 1'b1;
            gnt_out <= '0;
            ptr     <= ~owner;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        COLLECT: begin
          if (collect_fin) begin
            done_out <= gnt_out;
            gnt_out  <= '0;
            ptr      <= ~owner;
            state    <= IDLE;
          end else begin
            byte_acc <= {byte_acc[15:0], core_hash_in};
            byte_cnt <= byte_cnt + 5'd1;
            if (byte_cnt[1:0] == 2'd3) begin
              hash_valid_out <= 1'b1;
              hash_word_out  <= {byte_acc, core_hash_in};
              hash_idx_out   <= byte_cnt[4:2];
              hash_dst_out   <= owner;
            end
            if (byte_cnt == 5'd31)
              collect_fin <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SHA_ARB_TIMEOUT_EN
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed bench for sha256_core_arbiter with a byte-serial core stand-in.
// Covers reset, abc digest, round robin, stalled load, abandon, mid-collect reset and the WAIT watchdog.
module tb_sha256_core_arbiter;
  localparam int DW  = 32;
  localparam int PRE = 3;
  localparam int TO  = 64;
  localparam int LAT = 4;
  typedef logic [31:0] blk_t [16];

  localparam logic [31:0] ABC_DIG [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                          32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_in, gnt_out, ld_valid_in, ld_ready_out, done_out;
  logic [DW-1:0] ld_word0_in, ld_word1_in, core_msg_out;
  logic          core_start_out, hash_valid_out, hash_dst_out, err_out;
  logic          core_dv_in = 1'b0;
  logic [7:0]    core_hash_in = 8'h00;
  logic [31:0]   hash_word_out;
  logic [2:0]    hash_idx_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sha256_core_arbiter #(.DATA_WIDTH(DW), .PRE_CYC(PRE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .gnt_out(gnt_out),
    .ld_valid_in(ld_valid_in), .ld_word0_in(ld_word0_in), .ld_word1_in(ld_word1_in),
    .ld_ready_out(ld_ready_out), .core_start_out(core_start_out), .core_msg_out(core_msg_out),
    .core_hash_in(core_hash_in), .core_dv_in(core_dv_in), .hash_word_out(hash_word_out),
    .hash_valid_out(hash_valid_out), .hash_idx_out(hash_idx_out), .hash_dst_out(hash_dst_out),
    .done_out(done_out), .err_out(err_out));

  int          cyc = 0;
  blk_t        cap;
  logic [7:0]  dig [32];
  int          run_len = 0, feed_len = 0, pre_bad = 0, start_cycles = 0, resp_cnt = -1;
  bit          core_mute = 1'b0;
  int          wait_cyc = 0, gnt_cyc = 0, last_hv_cyc = 0, done_cyc = 0, err_cyc = 0;
  int          hv_n = 0, done_n = 0, err_n = 0, gnt_bad = 0, dst_bad = 0;
  logic [31:0] hw [8];
  logic [2:0]  hi [8];
  logic [1:0]  done_last = 2'b00;
  logic [1:0]  prev_gnt = 2'b00;
  logic        exp_dst = 1'b0;
  blk_t        b_abc, b_a, b_b, b_c;

  function automatic bit is_abc(input blk_t b);
    for (int i = 0; i < 16; i++)
      if (b[i] !== b_abc[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] stub_byte(input blk_t b, input int k);
    logic [31:0] w;
    w = b[k % 16];
    return w[7:0] ^ w[23:16] ^ 8'(k * 37);
  endfunction

  function automatic logic [7:0] dig_byte(input blk_t b, input int k);
    logic [31:0] w;
    if (!is_abc(b)) return stub_byte(b, k);
    w = ABC_DIG[k / 4];
    return w[8*(3 - k % 4) +: 8];
  endfunction

  function automatic logic [31:0] exp_word(input blk_t b, input int j);
    return {dig_byte(b, 4*j), dig_byte(b, 4*j+1), dig_byte(b, 4*j+2), dig_byte(b, 4*j+3)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: captures the fed block, then streams 32 digest bytes LAT cycles after start drops.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      run_len = 0; resp_cnt = -1; core_dv_in = 1'b0; core_hash_in = 8'h00;
    end else begin
      core_dv_in = 1'b0; core_hash_in = 8'h00;
      if (core_start_out === 1'b1) begin
        start_cycles++;
        if (run_len < PRE) begin
          if (core_msg_out !== '0) pre_bad++;
        end else if (run_len < PRE + 16) begin
          cap[run_len - PRE] = core_msg_out;
        end
        run_len++;
      end else if (run_len != 0) begin
        feed_len = run_len; run_len = 0; wait_cyc = cyc; resp_cnt = 0;
        for (int k = 0; k < 32; k++) dig[k] = dig_byte(cap, k);
      end
      if (resp_cnt >= 0 && !core_mute) begin
        if (resp_cnt >= LAT) begin
          core_dv_in   = (resp_cnt == LAT);
          core_hash_in = dig[resp_cnt - LAT];
          resp_cnt     = (resp_cnt == LAT + 31) ? -1 : resp_cnt + 1;
        end else begin
          resp_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (gnt_out !== 2'b00 && prev_gnt === 2'b00) gnt_cyc = cyc;
    prev_gnt = gnt_out;
    if (gnt_out !== 2'b00 && !$onehot(gnt_out)) gnt_bad++;
    if (hash_valid_out === 1'b1) begin
      if (hv_n < 8) begin hw[hv_n] = hash_word_out; hi[hv_n] = hash_idx_out; end
      if (hash_dst_out !== exp_dst) dst_bad++;
      hv_n++; last_hv_cyc = cyc;
    end
    if (done_out !== 2'b00) begin done_n++; done_last = done_out; done_cyc = cyc; end
    if (err_out === 1'b1) begin err_n++; err_cyc = cyc; end
  end

  task automatic clear_mon();
    hv_n = 0; done_n = 0; err_n = 0; dst_bad = 0; done_last = 2'b00;
    for (int j = 0; j < 8; j++) begin hw[j] = '0; hi[j] = '0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_in = 2'b00; ld_valid_in = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int t = 0; t < 10 && g == 2'b00; t++) begin @(negedge clk); g = gnt_out; end
  endtask

  task automatic load_words(input int r, input blk_t b, input int stall, input int drop_after);
    int i = 0;
    for (int t = 0; t < 400 && i < 16; t++) begin
      if (i == drop_after) begin req_in[r] = 1'b0; break; end
      ld_valid_in[r] = (stall == 0) || ($urandom_range(0, 99) >= stall);
      if (r == 0) ld_word0_in = b[i]; else ld_word1_in = b[i];
      if (ld_valid_in[r] && ld_ready_out[r]) i++;
      @(negedge clk);
    end
    ld_valid_in = 2'b00;
  endtask

  task automatic wait_done(input int limit);
    for (int t = 0; t < limit && done_n == 0 && err_n == 0; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt_out !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_out); end
    checks++; if (ld_ready_out !== 2'b00) begin errors++; $display("FAIL reset_ld_ready: got %b want 00", ld_ready_out); end
    checks++; if (core_start_out !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", core_start_out); end
    checks++; if (core_msg_out !== '0) begin errors++; $display("FAIL reset_core_msg: got %h want 0", core_msg_out); end
    checks++; if (hash_valid_out !== 1'b0) begin errors++; $display("FAIL reset_hash_valid: got %b want 0", hash_valid_out); end
    checks++; if (hash_word_out !== '0) begin errors++; $display("FAIL reset_hash_word: got %h want 0", hash_word_out); end
    checks++; if (done_out !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_out); end
  endtask

  task automatic test_abc();
    logic [1:0] g;
    clear_mon(); exp_dst = 1'b0;
    req_in = 2'b01;
    wait_grant(g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL abc_grant: got %b want 01", g); end
    load_words(0, b_abc, 0, -1);
    req_in = 2'b00;
    wait_done(200);
    checks++; if (feed_len != PRE + 16 || pre_bad != 0) begin errors++; $display("FAIL abc_feed_len: got %0d (pre_bad %0d) want 19 (0)", feed_len, pre_bad); end
    checks++; if (wait_cyc - gnt_cyc != 16 + PRE + 16) begin errors++; $display("FAIL abc_latency: got %0d want 35", wait_cyc - gnt_cyc); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (cap[i] !== b_abc[i]) begin errors++; $display("FAIL abc_fed_word%0d: got %h want %h", i, cap[i], b_abc[i]); end
    end
    checks++; if (hv_n != 8) begin errors++; $display("FAIL abc_hash_count: got %0d want 8", hv_n); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (hw[j] !== ABC_DIG[j] || hi[j] !== 3'(j)) begin errors++; $display("FAIL abc_hash_word%0d: got %h idx %0d want %h idx %0d", j, hw[j], hi[j], ABC_DIG[j], j); end
    end
    checks++; if (dst_bad != 0) begin errors++; $display("FAIL abc_dst: got %0d bad dst want 0", dst_bad); end
    checks++; if (done_last !== 2'b01 || done_n != 1) begin errors++; $display("FAIL abc_done: got %b x%0d want 01 x1", done_last, done_n); end
    checks++; if (done_cyc != last_hv_cyc + 1) begin errors++; $display("FAIL abc_done_timing: got %0d cycles after word7 want 1", done_cyc - last_hv_cyc); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    int n;
    do_reset();
    clear_mon(); exp_dst = 1'b0;
    req_in = 2'b11;
    wait_grant(g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b want 01", g); end
    load_words(0, b_a, 0, -1);
    wait_done(200);
    n = 0; for (int j = 0; j < 8; j++) if (hw[j] !== exp_word(b_a, j)) n++;
    checks++; if (hv_n != 8 || n != 0 || dst_bad != 0 || done_last !== 2'b01) begin errors++; $display("FAIL rr_block0: got %0d words %0d wrong dst_bad %0d done %b want 8 0 0 01", hv_n, n, dst_bad, done_last); end
    clear_mon(); exp_dst = 1'b1;
    wait_grant(g);
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b want 10", g); end
    checks++; if (gnt_cyc != done_cyc + 1) begin errors++; $display("FAIL rr_regrant_gap: got %0d want 1", gnt_cyc - done_cyc); end
    load_words(1, b_b, 0, -1);
    wait_done(200);
    n = 0; for (int j = 0; j < 8; j++) if (hw[j] !== exp_word(b_b, j)) n++;
    checks++; if (hv_n != 8 || n != 0 || dst_bad != 0 || done_last !== 2'b10) begin errors++; $display("FAIL rr_block1: got %0d words %0d wrong dst_bad %0d done %b want 8 0 0 10", hv_n, n, dst_bad, done_last); end
    clear_mon(); exp_dst = 1'b0;
    wait_grant(g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL rr_third_grant: got %b want 01", g); end
    req_in = 2'b01;
    load_words(0, b_a, 0, -1);
    req_in = 2'b00;
    wait_done(200);
    checks++; if (done_last !== 2'b01 || dst_bad != 0) begin errors++; $display("FAIL rr_third_done: got %b dst_bad %0d want 01 0", done_last, dst_bad); end
  endtask

  task automatic test_stall();
    logic [1:0] g;
    int n, s0;
    clear_mon(); exp_dst = 1'b1; s0 = start_cycles;
    req_in = 2'b10;
    wait_grant(g);
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL stall_grant: got %b want 10", g); end
    load_words(1, b_c, 40, -1);
    req_in = 2'b00;
    wait_done(300);
    checks++; if (feed_len != PRE + 16 || start_cycles - s0 != PRE + 16 || pre_bad != 0) begin errors++; $display("FAIL stall_start_run: got run %0d total %0d want 19 19", feed_len, start_cycles - s0); end
    n = 0; for (int i = 0; i < 16; i++) if (cap[i] !== b_c[i]) n++;
    checks++; if (n != 0) begin errors++; $display("FAIL stall_word_order: got %0d misplaced words want 0", n); end
    n = 0; for (int j = 0; j < 8; j++) if (hw[j] !== exp_word(b_c, j)) n++;
    checks++; if (hv_n != 8 || n != 0 || dst_bad != 0 || done_last !== 2'b10) begin errors++; $display("FAIL stall_hash: got %0d words %0d wrong dst_bad %0d done %b want 8 0 0 10", hv_n, n, dst_bad, done_last); end
  endtask

  task automatic test_abandon();
    logic [1:0] g;
    int n, s0;
    clear_mon(); exp_dst = 1'b0; s0 = start_cycles;
    req_in = 2'b01;
    wait_grant(g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL abandon_grant: got %b want 01", g); end
    load_words(0, b_a, 0, 7);
    repeat (2) @(negedge clk);
    checks++; if (gnt_out !== 2'b00 || ld_ready_out !== 2'b00) begin errors++; $display("FAIL abandon_idle: got gnt %b ready %b want 00 00", gnt_out, ld_ready_out); end
    repeat (30) @(negedge clk);
    checks++; if (start_cycles != s0 || done_n != 0) begin errors++; $display("FAIL abandon_no_core: got %0d start cycles %0d done want 0 0", start_cycles - s0, done_n); end
    req_in = 2'b11;
    wait_grant(g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL abandon_regrant: got %b want 01", g); end
    req_in = 2'b01;
    load_words(0, b_a, 0, -1);
    req_in = 2'b00;
    wait_done(200);
    n = 0; for (int j = 0; j < 8; j++) if (hw[j] !== exp_word(b_a, j)) n++;
    checks++; if (hv_n != 8 || n != 0 || done_last !== 2'b01) begin errors++; $display("FAIL abandon_retry: got %0d words %0d wrong done %b want 8 0 01", hv_n, n, done_last); end
  endtask

  task automatic test_reset_mid_collect();
    logic [1:0] g;
    int n;
    clear_mon(); exp_dst = 1'b1;
    req_in = 2'b10;
    wait_grant(g);
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL midrst_grant: got %b want 10", g); end
    load_words(1, b_b, 0, -1);
    req_in = 2'b00;
    for (int t = 0; t < 100 && core_dv_in !== 1'b1; t++) @(negedge clk);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (gnt_out !== 2'b00 || ld_ready_out !== 2'b00 || core_start_out !== 1'b0 || core_msg_out !== '0)
      begin errors++; $display("FAIL midrst_ctrl_outputs: got gnt %b ready %b start %b msg %h want all 0", gnt_out, ld_ready_out, core_start_out, core_msg_out); end
    checks++; if (hash_valid_out !== 1'b0 || hash_word_out !== '0 || hash_idx_out !== 3'd0 || hash_dst_out !== 1'b0 || done_out !== 2'b00 || err_out !== 1'b0)
      begin errors++; $display("FAIL midrst_hash_outputs: got valid %b word %h idx %0d dst %b done %b err %b want all 0", hash_valid_out, hash_word_out, hash_idx_out, hash_dst_out, done_out, err_out); end
    checks++; if (hv_n != 2) begin errors++; $display("FAIL midrst_words_before: got %0d want 2", hv_n); end
    repeat (40) @(negedge clk);
    checks++; if (done_n != 0 || hv_n != 2) begin errors++; $display("FAIL midrst_quiet: got done %0d words %0d want 0 2", done_n, hv_n); end
    clear_mon(); exp_dst = 1'b0;
    req_in = 2'b11;
    wait_grant(g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL midrst_next_grant: got %b want 01", g); end
    req_in = 2'b01;
    load_words(0, b_a, 0, -1);
    req_in = 2'b00;
    wait_done(200);
    n = 0; for (int j = 0; j < 8; j++) if (hw[j] !== exp_word(b_a, j)) n++;
    checks++; if (hv_n != 8 || n != 0 || done_last !== 2'b01) begin errors++; $display("FAIL midrst_next_hash: got %0d words %0d wrong done %b want 8 0 01", hv_n, n, done_last); end
  endtask

  task automatic test_timeout();
    logic [1:0] g;
    clear_mon(); exp_dst = 1'b1; core_mute = 1'b1;
    req_in = 2'b10;
    wait_grant(g);
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL timeout_grant: got %b want 10", g); end
    load_words(1, b_c, 0, -1);
    req_in = 2'b00;
`ifdef SHA_ARB_TIMEOUT_EN
    for (int t = 0; t < 200 && err_n == 0; t++) @(negedge clk);
    checks++; if (err_n != 1 || err_cyc - wait_cyc != TO) begin errors++; $display("FAIL timeout_err: got %0d pulses at %0d cycles want 1 at %0d", err_n, err_cyc - wait_cyc, TO); end
    checks++; if (done_n != 0 || gnt_out !== 2'b00) begin errors++; $display("FAIL timeout_idle: got done %0d gnt %b want 0 00", done_n, gnt_out); end
    req_in = 2'b11;
    wait_grant(g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL timeout_ptr: got %b want 01", g); end
`else
    repeat (300) @(negedge clk);
    checks++; if (err_n != 0) begin errors++; $display("FAIL noto_err: got %0d pulses want 0", err_n); end
    checks++; if (gnt_out !== 2'b10 || done_n != 0 || core_start_out !== 1'b0) begin errors++; $display("FAIL noto_wait: got gnt %b done %0d start %b want 10 0 0", gnt_out, done_n, core_start_out); end
`endif
    do_reset();
    core_mute = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_in = 2'b00; ld_valid_in = 2'b00; ld_word0_in = '0; ld_word1_in = '0;
    for (int i = 0; i < 16; i++) begin
      b_abc[i] = 32'h0;
      b_a[i]   = 32'h0A0B0000 + 32'(i * 257);
      b_b[i]   = 32'hB5000000 ^ 32'(i * 32'h01030507);
      b_c[i]   = 32'hC0DE0000 + 32'(i * i * 13 + i);
    end
    b_abc[0] = 32'h61626380;
    b_abc[15] = 32'h00000018;
    test_reset();
    test_abc();
    test_round_robin();
    test_stall();
    test_abandon();
    test_reset_mid_collect();
    test_timeout();
    checks++; if (gnt_bad != 0) begin errors++; $display("FAIL gnt_onehot: got %0d non-one-hot cycles want 0", gnt_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
